// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller for the 4-bit CPU: sequences ROM fetches, drives the
// PC controls, and owns the accumulator, its flags and the ready/valid output port.
module instruction_sequencer #(
  parameter int ACC_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [7:0]       pc,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic             halt,
  output logic             jump_enable,
  output logic [7:0]       jump_addr,
  output logic             pc_inc_2,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             halted,
  output logic             illegal_op
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_OUT_WAIT,
    S_HALTED
  } state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_ir, w_ir_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_halted, w_halted_nxt;
  logic             r_illegal, w_illegal_nxt;

  logic [3:0]       w_op;
  logic [ACC_W-1:0] w_imm;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_diff;
  logic             w_taken;

  assign w_op   = rom_data[7:4];
  assign w_imm  = rom_data[ACC_W-1:0];
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_imm};
  assign w_diff = r_acc - w_imm;
  // Branch condition uses the flags as they stand when the operand byte arrives.
  assign w_taken = (r_ir == OP_JMP) || ((r_ir == OP_JZ) && r_zero) ||
                   ((r_ir == OP_JC) && r_carry);

  always_comb begin
    w_next        = r_state;
    w_ir_nxt      = r_ir;
    w_acc_nxt     = r_acc;
    w_zero_nxt    = r_zero;
    w_carry_nxt   = r_carry;
    w_halted_nxt  = r_halted;
    w_illegal_nxt = 1'b0;
    rom_addr      = pc;
    halt          = 1'b1;
    jump_enable   = 1'b0;
    jump_addr     = 8'h00;
    pc_inc_2      = 1'b0;
    out_valid     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (run) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_op)
          OP_NOP: begin
            halt   = 1'b0;
            w_next = S_FETCH;
          end
          OP_LDI: begin
            halt       = 1'b0;
            w_next     = S_FETCH;
            w_acc_nxt  = w_imm;
            w_zero_nxt = (w_imm == '0);
          end
          OP_ADDI: begin
            halt                     = 1'b0;
            w_next                   = S_FETCH;
            {w_carry_nxt, w_acc_nxt} = w_sum;
            w_zero_nxt               = (w_sum[ACC_W-1:0] == '0);
          end
          OP_SUBI: begin
            halt        = 1'b0;
            w_next      = S_FETCH;
            w_acc_nxt   = w_diff;
            w_carry_nxt = (r_acc < w_imm);
            w_zero_nxt  = (w_diff == '0);
          end
          OP_JMP, OP_JZ, OP_JC: begin
            // Prefetch the target byte while the PC is still frozen on the opcode.
            w_ir_nxt = w_op;
            rom_addr = pc + 8'd1;
            w_next   = S_OPERAND;
          end
          OP_OUT: w_next = S_OUT_WAIT;
          OP_HLT: begin
            w_next       = S_HALTED;
            w_halted_nxt = 1'b1;
          end
          default: begin
            halt          = 1'b0;
            w_illegal_nxt = 1'b1;
            w_next        = S_FETCH;
          end
        endcase
      end
      S_OPERAND: begin
        halt   = 1'b0;
        w_next = S_FETCH;
        if (w_taken) begin
          jump_enable = 1'b1;
          jump_addr   = rom_data;
        end else begin
          pc_inc_2 = 1'b1;
        end
      end
      S_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          halt   = 1'b0;
          w_next = S_FETCH;
        end
      end
      S_HALTED: ;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_ir      <= 4'h0;
      r_acc     <= '0;
      r_zero    <= 1'b1;
      r_carry   <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ir      <= w_ir_nxt;
      r_acc     <= w_acc_nxt;
      r_zero    <= w_zero_nxt;
      r_carry   <= w_carry_nxt;
      r_halted  <= w_halted_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  assign acc        = r_acc;
  assign out_data   = r_acc;
  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;
  assign halted     = r_halted;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: PC + ROM around the DUT, an instruction-level
// reference model checked every cycle, directed programs and randomized programs.
module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, run, out_ready;
  logic [7:0] pc, rom_addr, rom_data, jump_addr;
  logic       halt, jump_enable, pc_inc_2, out_valid;
  logic [3:0] out_data, acc;
  logic       zero_flag, carry_flag, halted, illegal_op;

  logic [7:0] rom [256];

  instruction_sequencer #(.ACC_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pc(pc), .rom_addr(rom_addr),
    .rom_data(rom_data), .halt(halt), .jump_enable(jump_enable), .jump_addr(jump_addr),
    .pc_inc_2(pc_inc_2), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) pc <= 8'h00;
    else if (!halt) pc <= jump_enable ? jump_addr : (pc_inc_2 ? pc + 8'd2 : pc + 8'd1);

  always @(posedge clk) rom_data <= rom[rom_addr];

  int errors = 0, checks = 0;

  // Reference model: architectural state plus where we are inside the current instruction.
  localparam int PH_IDLE = 0, PH_OPC = 1, PH_TGT = 2, PH_OUT = 3, PH_STOP = 4;
  int m_pc, m_acc, m_z, m_c, m_halted, m_ill, ph, m_ir;

  int je_cnt = 0, inc2_cnt = 0, ill_cnt = 0, ov_cnt = 0, ovh_cnt = 0, hs_cnt = 0;
  int pc2_cnt = 0, wrap_cnt = 0, ja_last = 0, hs_data = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    int e_halt, e_je, e_inc2, e_ov, e_ra, e_ja;
    int n_pc, n_acc, n_z, n_c, n_halted, n_ill, n_ph, n_ir, op, imm, tgt, t;
    bit taken;
    if (!reset_n) begin
      chk("rst_halt", 32'(halt), 1);         chk("rst_je", 32'(jump_enable), 0);
      chk("rst_inc2", 32'(pc_inc_2), 0);     chk("rst_ja", 32'(jump_addr), 0);
      chk("rst_ov", 32'(out_valid), 0);      chk("rst_acc", 32'(acc), 0);
      chk("rst_z", 32'(zero_flag), 1);       chk("rst_c", 32'(carry_flag), 0);
      chk("rst_halted", 32'(halted), 0);     chk("rst_ill", 32'(illegal_op), 0);
      m_pc = 0; m_acc = 0; m_z = 1; m_c = 0; m_halted = 0; m_ill = 0; ph = PH_IDLE; m_ir = 0;
      return;
    end
    je_cnt += 32'(jump_enable);
    if (jump_enable) ja_last = 32'(jump_addr);
    inc2_cnt += 32'(pc_inc_2);
    ill_cnt  += 32'(illegal_op);
    if (out_valid) ov_cnt++;
    if (out_valid && halt) ovh_cnt++;
    if (out_valid && out_ready) begin hs_cnt++; hs_data = 32'(out_data); end
    if (pc == 8'h02) pc2_cnt++;
    if (pc == 8'hFF && rom_addr == 8'h00) wrap_cnt++;

    e_halt = 1; e_je = 0; e_inc2 = 0; e_ov = 0; e_ra = m_pc; e_ja = 0;
    n_pc = m_pc; n_acc = m_acc; n_z = m_z; n_c = m_c; n_halted = m_halted;
    n_ill = 0; n_ph = ph; n_ir = m_ir;
    op = m_ir / 16; imm = m_ir % 16;
    case (ph)
      PH_IDLE: if (run) begin n_ir = 32'(rom[m_pc]); n_ph = PH_OPC; end
      PH_OPC: begin
        if (op >= 4 && op <= 6) begin
          e_ra = (m_pc + 1) % 256; n_ph = PH_TGT;
        end else if (op == 7) n_ph = PH_OUT;
        else if (op == 15) begin n_ph = PH_STOP; n_halted = 1; end
        else begin
          e_halt = 0; n_pc = (m_pc + 1) % 256; n_ph = PH_IDLE;
          if (op == 1) begin n_acc = imm; n_z = (imm == 0); end
          else if (op == 2) begin
            t = m_acc + imm; n_c = (t > 15); n_acc = t % 16; n_z = (n_acc == 0);
          end else if (op == 3) begin
            n_c = (m_acc < imm); n_acc = (m_acc - imm + 16) % 16; n_z = (n_acc == 0);
          end else if (op >= 8) n_ill = 1;
        end
      end
      PH_TGT: begin
        tgt = 32'(rom[(m_pc + 1) % 256]);
        taken = (op == 4) || (op == 5 && m_z == 1) || (op == 6 && m_c == 1);
        e_halt = 0; n_ph = PH_IDLE;
        if (taken) begin e_je = 1; e_ja = tgt; n_pc = tgt; end
        else begin e_inc2 = 1; n_pc = (m_pc + 2) % 256; end
      end
      PH_OUT: begin
        e_ov = 1; e_halt = out_ready ? 0 : 1;
        if (out_ready) begin n_pc = (m_pc + 1) % 256; n_ph = PH_IDLE; end
      end
      default: ;
    endcase

    chk("halt", 32'(halt), e_halt);           chk("jump_enable", 32'(jump_enable), e_je);
    chk("pc_inc_2", 32'(pc_inc_2), e_inc2);   chk("jump_addr", 32'(jump_addr), e_ja);
    chk("out_valid", 32'(out_valid), e_ov);   chk("rom_addr", 32'(rom_addr), e_ra);
    chk("pc", 32'(pc), m_pc);                 chk("acc", 32'(acc), m_acc);
    chk("zero_flag", 32'(zero_flag), m_z);    chk("carry_flag", 32'(carry_flag), m_c);
    chk("halted", 32'(halted), m_halted);     chk("illegal_op", 32'(illegal_op), m_ill);
    if (e_ov == 1) chk("out_data", 32'(out_data), m_acc);

    m_pc = n_pc; m_acc = n_acc; m_z = n_z; m_c = n_c; m_halted = n_halted;
    m_ill = n_ill; ph = n_ph; m_ir = n_ir;
  endtask

  // Inputs change 1 time unit after a rising edge; the model is checked on falling edges.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic start_prog();
    reset_n = 1'b0; run = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic run_until_halt(input int max);
    for (int i = 0; i < max && !halted; i++) step();
    chk("halt_reached", 32'(halted), 1);
  endtask

  int je0, inc0, ill0, ov0, ovh0, hs0, pc20, wr0;
  task automatic snap();
    je0 = je_cnt; inc0 = inc2_cnt; ill0 = ill_cnt; ov0 = ov_cnt; ovh0 = ovh_cnt;
    hs0 = hs_cnt; pc20 = pc2_cnt; wr0 = wrap_cnt;
  endtask

  initial begin
    reset_n = 1'b1; run = 1'b0; out_ready = 1'b0;
    fill(8'hF0);
    #2 reset_n = 1'b0;
    @(posedge clk); #1;

    // LDI 3; ADDI 13; JZ 07; ... OUT; HLT
    fill(8'hF0);
    rom[8'h00] = 8'h13; rom[8'h01] = 8'h2D; rom[8'h02] = 8'h50; rom[8'h03] = 8'h07;
    rom[8'h07] = 8'h70; rom[8'h08] = 8'hF0;
    out_ready = 1'b1; snap(); start_prog(); run = 1'b1;
    step(); step();
    chk("t1_ldi_acc", 32'(acc), 3);
    step(); step();
    chk("t1_addi_acc", 32'(acc), 0);
    chk("t1_addi_z", 32'(zero_flag), 1);
    chk("t1_addi_c", 32'(carry_flag), 1);
    run_until_halt(60);
    step(); step(); step();
    chk("t1_pc", 32'(pc), 8'h08);
    chk("t1_je_pulses", je_cnt - je0, 1);
    chk("t1_jump_addr", ja_last, 8'h07);
    chk("t1_handshakes", hs_cnt - hs0, 1);
    chk("t1_out_data", hs_data, 0);

    // Same program, ADDI 1: JZ not taken
    rom[8'h01] = 8'h21; rom[8'h04] = 8'hF0;
    snap(); start_prog(); run = 1'b1;
    run_until_halt(60);
    chk("t2_acc", 32'(acc), 4);
    chk("t2_z", 32'(zero_flag), 0);
    chk("t2_c", 32'(carry_flag), 0);
    chk("t2_inc2_pulses", inc2_cnt - inc0, 1);
    chk("t2_je_pulses", je_cnt - je0, 0);
    chk("t2_pc", 32'(pc), 8'h04);
    chk("t2_jz_cycles", pc2_cnt - pc20, 3);

    // JMP at 0xFF whose operand wraps to address 0x00
    fill(8'hF0);
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h40; rom[8'h02] = 8'hFF; rom[8'hFF] = 8'h40;
    snap(); start_prog(); run = 1'b1;
    run_until_halt(60);
    chk("t3_wrap_addr", wr0 == wrap_cnt ? 0 : wrap_cnt - wr0, 1);
    chk("t3_pc", 32'(pc), 8'h10);

    // OUT with out_ready low for five valid cycles
    fill(8'hF0);
    rom[8'h00] = 8'h15; rom[8'h01] = 8'h70;
    out_ready = 1'b0; snap(); start_prog(); run = 1'b1;
    for (int i = 0; i < 60 && !halted; i++) begin
      out_ready = (ov_cnt - ov0 >= 5);
      step();
    end
    chk("t4_halted", 32'(halted), 1);
    chk("t4_valid_cycles", ov_cnt - ov0, 6);
    chk("t4_stall_cycles", ovh_cnt - ovh0, 5);
    chk("t4_handshakes", hs_cnt - hs0, 1);
    chk("t4_out_data", hs_data, 5);
    chk("t4_pc", 32'(pc), 8'h02);

    // Illegal opcode then SUBI 1 from zero
    fill(8'hF0);
    rom[8'h00] = 8'h9A; rom[8'h01] = 8'h31;
    out_ready = 1'b1; snap(); start_prog(); run = 1'b1;
    run_until_halt(60);
    chk("t5_ill_pulses", ill_cnt - ill0, 1);
    chk("t5_acc", 32'(acc), 4'hF);
    chk("t5_c", 32'(carry_flag), 1);
    chk("t5_z", 32'(zero_flag), 0);
    chk("t5_pc", 32'(pc), 8'h02);

    // Reset during OPERAND of a JMP, then idle with run low
    fill(8'hF0);
    rom[8'h00] = 8'h40; rom[8'h01] = 8'h20;
    snap(); start_prog(); run = 1'b1;
    step(); step();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_je", 32'(jump_enable), 0);
    chk("t6_rst_halt", 32'(halt), 1);
    run = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t6_je_pulses", je_cnt - je0, 0);
    chk("t6_idle_pc", 32'(pc), 0);
    chk("t6_idle_halt", 32'(halt), 1);

    // Randomized programs with random run/out_ready and occasional mid-run resets
    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < 256; a++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'h0;
        rom[a] = b;
      end
      start_prog();
      for (int c = 0; c < 400; c++) begin
        run = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 199) == 0) begin
          reset_n = 1'b0; step(); step();
          reset_n = 1'b1;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
